// File: rtl/i2c_master_byte_seq_pkg.sv
// Shared definitions for the I2C byte sequencer: bit-controller command
// encodings and the one-hot sequencer state encoding.
package i2c_master_byte_seq_pkg;

    localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
    localparam logic [3:0] I2C_CMD_START = 4'b0001;
    localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
    localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
    localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_START = 6'b000010,
        ST_WRITE = 6'b000100,
        ST_READ  = 6'b001000,
        ST_ACK   = 6'b010000,
        ST_STOP  = 6'b100000
    } seq_state_e;

endpackage

// File: rtl/i2c_master_byte_seq_if.sv
// Link between the byte sequencer (master) and the I2C bit controller (slave).
// Signal suffixes are from the sequencer's point of view.
interface i2c_master_byte_seq_if;
    logic [3:0] core_cmd_o;
    logic       core_txd_o;
    logic       core_ack_i;
    logic       core_rxd_i;
    logic       core_al_i;

    modport master (
        output core_cmd_o, core_txd_o,
        input  core_ack_i, core_rxd_i, core_al_i
    );

    modport slave (
        input  core_cmd_o, core_txd_o,
        output core_ack_i, core_rxd_i, core_al_i
    );
endinterface

// File: rtl/i2c_byte_shreg.sv
// 8-bit MSB-first shift register with a 3-bit down counter; done_o flags the
// last bit of the byte (count == 0).
module i2c_byte_shreg (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] din_i,
    input  logic       rxd_i,
    output logic [7:0] sr_o,
    output logic       done_o
);

    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = din_i;
            cnt_d = 3'd7;
        end else if (shift_i) begin
            sr_d  = {sr_q[6:0], rxd_i};
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q  <= 8'h00;
            cnt_q <= 3'd0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr_o   = sr_q;
    assign done_o = (cnt_q == 3'd0);

endmodule

// File: rtl/i2c_master_byte_seq.sv
// I2C byte sequencer: turns start/read/write/stop/ack requests into bit
// controller commands. Optional bus timeout under I2C_BYTE_SEQ_TIMEOUT_EN.
module i2c_master_byte_seq
    import i2c_master_byte_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       read_i,
    input  logic       write_i,
    input  logic       ack_i,
    input  logic [7:0] din_i,
    output logic       cmd_ack_o,
    output logic       ack_o,
    output logic [7:0] dout_o,
    output logic       al_o,
    output logic       timeout_o,
    i2c_master_byte_seq_if.master core
);

    seq_state_e state_q;
    logic [3:0] cmd_q;
    logic       txd_q;
    logic       cmd_ack_q;
    logic       ack_q;
    logic [7:0] dout_q;
    logic       al_q;
    logic       timeout_q;

    logic [7:0] sr;
    logic       done;
    logic       req_any;
    logic       accept;
    logic       shift;
    logic       timeout_hit;

    assign req_any = start_i | read_i | write_i | stop_i;
    // Requests are held until cmd_ack_o, so the completion cycle must not re-accept them.
    assign accept  = (state_q == ST_IDLE) && !cmd_ack_q && req_any && !core.core_al_i;
    assign shift   = ((state_q == ST_WRITE) || (state_q == ST_READ)) && core.core_ack_i
                     && !core.core_al_i && !timeout_hit;

    i2c_byte_shreg u_shreg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (accept),
        .shift_i (shift),
        .din_i   (din_i),
        .rxd_i   (core.core_rxd_i),
        .sr_o    (sr),
        .done_o  (done)
    );

`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] to_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q == ST_IDLE) || core.core_ack_i) begin
            to_q <= '0;
        end else begin
            to_q <= to_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q != ST_IDLE) && (to_q == TO_W'(TIMEOUT_CYCLES));
`else
    logic [31:0] unused_to_cfg;
    assign unused_to_cfg = TO_W + TIMEOUT_CYCLES;
    assign timeout_hit   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cmd_q     <= I2C_CMD_NOP;
            txd_q     <= 1'b0;
            cmd_ack_q <= 1'b0;
            ack_q     <= 1'b0;
            dout_q    <= 8'h00;
            al_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cmd_ack_q <= 1'b0;
            al_q      <= 1'b0;
            timeout_q <= 1'b0;
            if (core.core_al_i) begin
                state_q <= ST_IDLE;
                cmd_q   <= I2C_CMD_NOP;
                al_q    <= 1'b1;
            end else if (timeout_hit) begin
                state_q   <= ST_IDLE;
                cmd_q     <= I2C_CMD_NOP;
                timeout_q <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            if (start_i) begin
                                state_q <= ST_START;
                                cmd_q   <= I2C_CMD_START;
                            end else if (read_i) begin
                                state_q <= ST_READ;
                                cmd_q   <= I2C_CMD_READ;
                            end else if (write_i) begin
                                state_q <= ST_WRITE;
                                cmd_q   <= I2C_CMD_WRITE;
                                txd_q   <= din_i[7];
                            end else begin
                                state_q <= ST_STOP;
                                cmd_q   <= I2C_CMD_STOP;
                            end
                        end
                    end
                    ST_START: begin
                        if (core.core_ack_i) begin
                            if (read_i) begin
                                state_q <= ST_READ;
                                cmd_q   <= I2C_CMD_READ;
                            end else if (write_i) begin
                                state_q <= ST_WRITE;
                                cmd_q   <= I2C_CMD_WRITE;
                                txd_q   <= sr[7];
                            end else if (stop_i) begin
                                state_q <= ST_STOP;
                                cmd_q   <= I2C_CMD_STOP;
                            end else begin
                                state_q   <= ST_IDLE;
                                cmd_q     <= I2C_CMD_NOP;
                                cmd_ack_q <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE, ST_READ: begin
                        if (core.core_ack_i) begin
                            if (done) begin
                                state_q <= ST_ACK;
                                if (state_q == ST_READ) begin
                                    cmd_q <= I2C_CMD_WRITE;
                                    txd_q <= ack_i;
                                end else begin
                                    cmd_q <= I2C_CMD_READ;
                                end
                            end else begin
                                // sr[6] becomes the MSB once this ack's shift lands
                                txd_q <= sr[6];
                            end
                        end
                    end
                    ST_ACK: begin
                        if (core.core_ack_i) begin
                            ack_q  <= core.core_rxd_i;
                            dout_q <= sr;
                            if (stop_i) begin
                                state_q <= ST_STOP;
                                cmd_q   <= I2C_CMD_STOP;
                            end else begin
                                state_q   <= ST_IDLE;
                                cmd_q     <= I2C_CMD_NOP;
                                cmd_ack_q <= 1'b1;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (core.core_ack_i) begin
                            state_q   <= ST_IDLE;
                            cmd_q     <= I2C_CMD_NOP;
                            cmd_ack_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cmd_q   <= I2C_CMD_NOP;
                    end
                endcase
            end
        end
    end

    assign core.core_cmd_o = cmd_q;
    assign core.core_txd_o = txd_q;
    assign cmd_ack_o       = cmd_ack_q;
    assign ack_o           = ack_q;
    assign dout_o          = dout_q;
    assign al_o            = al_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_i2c_master_byte_seq.sv
// Randomized self-checking bench for i2c_master_byte_seq; the bit controller
// is emulated here and each request is checked against a command-list model.
module tb_i2c_master_byte_seq;
    import i2c_master_byte_seq_pkg::*;

    localparam int TO_CYC = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i, stop_i, read_i, write_i, ack_i;
    logic [7:0] din_i;
    logic       cmd_ack_o, ack_o, al_o, timeout_o;
    logic [7:0] dout_o;

    i2c_master_byte_seq_if core_if ();

    always #5 clk = ~clk;

    i2c_master_byte_seq #(
        .TIMEOUT_CYCLES (TO_CYC),
        .TO_W           (16)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .ack_i     (ack_i),
        .din_i     (din_i),
        .cmd_ack_o (cmd_ack_o),
        .ack_o     (ack_o),
        .dout_o    (dout_o),
        .al_o      (al_o),
        .timeout_o (timeout_o),
        .core      (core_if)
    );

    typedef struct {
        logic [3:0] cmd;
        bit         chk_txd;
        logic       txd;
        bit         is_data;
        logic       rxd;
    } step_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_txn   = 0;
    logic [7:0] exp_dout = 8'h00;
    logic       exp_ack  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_reqs();
        start_i = 1'b0;
        stop_i  = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd"},    32'(core_if.core_cmd_o), 32'(I2C_CMD_NOP));
        check_eq({tag, "_txd"},    32'(core_if.core_txd_o), 32'd0);
        check_eq({tag, "_cmdack"}, 32'(cmd_ack_o), 32'd0);
        check_eq({tag, "_ack"},    32'(ack_o), 32'd0);
        check_eq({tag, "_dout"},   32'(dout_o), 32'd0);
        check_eq({tag, "_al"},     32'(al_o), 32'd0);
        check_eq({tag, "_to"},     32'(timeout_o), 32'd0);
    endtask

    // abort_at > 0 injects an abort after that many data-bit acks:
    // arbitration loss (with a coincident ack) or, if abort_rst, a reset.
    task automatic run_txn(input bit s, input bit p, input bit r, input bit w,
                           input logic [7:0] din, input bit acki,
                           input logic [7:0] rx, input bit rxack,
                           input int abort_at, input bit abort_rst);
        step_t q[$];
        step_t st;
        int    dcount;
        int    gap;
        if (s) begin
            st = '{I2C_CMD_START, 1'b0, 1'b0, 1'b0, 1'($urandom)};
            q.push_back(st);
        end
        if (r || w) begin
            for (int k = 0; k < 8; k++) begin
                if (r) st = '{I2C_CMD_READ, 1'b0, 1'b0, 1'b1, rx[7-k]};
                else   st = '{I2C_CMD_WRITE, 1'b1, din[7-k], 1'b1, rx[7-k]};
                q.push_back(st);
            end
            if (r) st = '{I2C_CMD_WRITE, 1'b1, acki, 1'b0, rxack};
            else   st = '{I2C_CMD_READ, 1'b0, 1'b0, 1'b0, rxack};
            q.push_back(st);
        end
        if (p) begin
            st = '{I2C_CMD_STOP, 1'b0, 1'b0, 1'b0, 1'($urandom)};
            q.push_back(st);
        end
        n_txn++;
        $display("[TB] txn %0d: s=%0d p=%0d r=%0d w=%0d din=%02h ack_i=%0d rx=%02h rxack=%0d steps=%0d abort=%0d%s",
                 n_txn, s, p, r, w, din, acki, rx, rxack, q.size(), abort_at, abort_rst ? " (reset)" : "");

        start_i = s; stop_i = p; read_i = r; write_i = w;
        din_i = din; ack_i = acki;
        dcount = 0;
        @(negedge clk);
        foreach (q[i]) begin
            check_eq("cmd", 32'(core_if.core_cmd_o), 32'(q[i].cmd));
            if (q[i].chk_txd) check_eq("txd", 32'(core_if.core_txd_o), 32'(q[i].txd));
            check_eq("busy_cmdack", 32'(cmd_ack_o), 32'd0);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge clk);
                check_eq("cmd_hold", 32'(core_if.core_cmd_o), 32'(q[i].cmd));
            end
            core_if.core_ack_i = 1'b1;
            core_if.core_rxd_i = q[i].rxd;
            @(negedge clk);
            core_if.core_ack_i = 1'b0;
            core_if.core_rxd_i = 1'($urandom);
            if (q[i].is_data) dcount++;
            if (abort_at > 0 && q[i].is_data && dcount == abort_at) begin
                clear_reqs();
                if (abort_rst) begin
                    rst = 1'b1;
                end else begin
                    core_if.core_al_i  = 1'b1;
                    core_if.core_ack_i = 1'b1;
                end
                @(negedge clk);
                rst = 1'b0;
                core_if.core_al_i  = 1'b0;
                core_if.core_ack_i = 1'b0;
                if (abort_rst) begin
                    exp_dout = 8'h00;
                    exp_ack  = 1'b0;
                    check_reset_outputs("rst_abort");
                end else begin
                    check_eq("al_cmd",    32'(core_if.core_cmd_o), 32'(I2C_CMD_NOP));
                    check_eq("al_pulse",  32'(al_o), 32'd1);
                    check_eq("al_cmdack", 32'(cmd_ack_o), 32'd0);
                    check_eq("al_dout",   32'(dout_o), 32'(exp_dout));
                end
                @(negedge clk);
                check_eq("abort_al_end",  32'(al_o), 32'd0);
                check_eq("abort_cmdack",  32'(cmd_ack_o), 32'd0);
                check_eq("abort_cmd_nop", 32'(core_if.core_cmd_o), 32'(I2C_CMD_NOP));
                return;
            end
        end
        if (r || w) begin
            exp_dout = rx;
            exp_ack  = rxack;
        end
        check_eq("done_cmdack", 32'(cmd_ack_o), 32'd1);
        check_eq("done_cmd",    32'(core_if.core_cmd_o), 32'(I2C_CMD_NOP));
        check_eq("done_dout",   32'(dout_o), 32'(exp_dout));
        check_eq("done_ack",    32'(ack_o), 32'(exp_ack));
        check_eq("done_al",     32'(al_o), 32'd0);
        clear_reqs();
        @(negedge clk);
        check_eq("cmdack_pulse", 32'(cmd_ack_o), 32'd0);
        check_eq("idle_cmd",     32'(core_if.core_cmd_o), 32'(I2C_CMD_NOP));
    endtask

    task automatic run_timeout();
        int n;
        int seen;
        n_txn++;
        $display("[TB] txn %0d: write 8'hC3 with core_ack withheld", n_txn);
        write_i = 1'b1;
        din_i   = 8'hC3;
        @(negedge clk);
        check_eq("to_cmd", 32'(core_if.core_cmd_o), 32'(I2C_CMD_WRITE));
        check_eq("to_txd", 32'(core_if.core_txd_o), 32'd1);
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
        n = 0;
        seen = 0;
        while (n < 300 && seen == 0) begin
            @(negedge clk);
            n++;
            if (timeout_o) seen = 1;
        end
        clear_reqs();
        check_eq("to_seen",   32'(seen), 32'd1);
        check_eq("to_window", 32'(n >= TO_CYC - 5 && n <= TO_CYC + 5), 32'd1);
        check_eq("to_cmd_nop", 32'(core_if.core_cmd_o), 32'(I2C_CMD_NOP));
        check_eq("to_cmdack",  32'(cmd_ack_o), 32'd0);
        @(negedge clk);
        check_eq("to_pulse_end", 32'(timeout_o), 32'd0);
        check_eq("to_idle_cmd",  32'(core_if.core_cmd_o), 32'(I2C_CMD_NOP));
`else
        seen = 0;
        for (n = 0; n < TO_CYC + 50; n++) begin
            @(negedge clk);
            if (timeout_o) seen++;
        end
        check_eq("no_timeout", 32'(seen), 32'd0);
        check_eq("still_busy", 32'(core_if.core_cmd_o), 32'(I2C_CMD_WRITE));
        clear_reqs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_dout = 8'h00;
        exp_ack  = 1'b0;
        check_reset_outputs("to_rst");
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] f;
        rst = 1'b1;
        clear_reqs();
        ack_i = 1'b0;
        din_i = 8'h00;
        core_if.core_ack_i = 1'b0;
        core_if.core_rxd_i = 1'b0;
        core_if.core_al_i  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        run_txn(1, 0, 0, 1, 8'hA5, 0, 8'h5A, 0, 0, 0);
        run_txn(0, 1, 1, 0, 8'h00, 1, 8'h3C, 1, 0, 0);
        run_txn(0, 0, 0, 1, 8'h96, 0, 8'hFF, 0, 4, 0);
        run_txn(0, 1, 0, 0, 8'h77, 0, 8'h00, 1, 0, 0);
        run_txn(0, 0, 1, 0, 8'h00, 0, 8'hB2, 1, 5, 1);
        run_txn(0, 0, 0, 1, 8'h01, 0, 8'h01, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            f = 4'($urandom_range(1, 15));
            run_txn(f[3], f[2], f[1], f[0], 8'($urandom), 1'($urandom),
                    8'($urandom), 1'($urandom), 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        run_timeout();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_byte_seq.md
Name: i2c_master_byte_seq

Overview:
Byte-level sequencer for the I2C master bit controller. It converts register-layer requests (start / write / read / stop / ack) into the 4-bit bit-level command stream, shifts 8 data bits plus the ACK bit, and reports completion, the received ACK and arbitration loss. It sits between the register/bus interface and the bit controller and is the only driver of the bit controller's `cmd_i` and `dat_i`.

Parameters:
- TIMEOUT_CYCLES, 65535: max clk_i cycles allowed between consecutive bit-controller acks. Used only with the optional feature.
- TO_W, 16: width of the timeout counter.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  generate (repeated) START before the byte
- stop_i  in  1  generate STOP after the byte
- read_i  in  1  read a byte
- write_i  in  1  write a byte
- ack_i  in  1  ACK bit master sends after a read (0 = ACK, 1 = NACK)
- din_i  in  8  byte to transmit
- cmd_ack_o  out  1  1-cycle pulse, request complete
- ack_o  out  1  ACK bit sampled from slave after a write
- dout_o  out  8  received byte
- al_o  out  1  arbitration lost, 1-cycle pulse
- timeout_o  out  1  1-cycle pulse, bus timeout
- core_cmd_o  out  4  command to bit controller (NOP/START/STOP/WRITE/READ)
- core_txd_o  out  1  bit to bit controller
- core_ack_i  in  1  bit controller command acknowledge
- core_rxd_i  in  1  bit from bit controller
- core_al_i  in  1  bit controller arbitration lost

Behaviour:
- Reset (rst_i=1, sync): state IDLE; core_cmd_o=NOP; core_txd_o=0; cmd_ack_o=0; ack_o=0; dout_o=8'h00; al_o=0; timeout_o=0; bit count=0.
- Reset mid-operation aborts immediately; no cmd_ack_o is issued.
- All outputs are registered. `core_cmd_o` is a level, held until `core_ack_i`. It is updated on the same edge that samples `core_ack_i`, so the next command is visible the following cycle.
- States: IDLE, START, WRITE, READ, ACK, STOP.
- IDLE, request acceptance:
  - If any of start_i / read_i / write_i / stop_i is 1, load shift reg = din_i and count = 7.
  - Priority: start -> START (cmd START); else read -> READ (cmd READ); else write -> WRITE (cmd WRITE, txd = din_i[7]); else stop -> STOP (cmd STOP).
  - Request inputs must stay stable until cmd_ack_o. They are not re-sampled in IDLE during the cmd_ack_o cycle.
- START, on core_ack: read -> READ; else write -> WRITE; else stop -> STOP; else IDLE with cmd_ack_o.
- WRITE / READ, on each core_ack:
  - shift reg <= {sr[6:0], core_rxd_i}; count--.
  - txd = next MSB.
  - At count==0 with ack: go to ACK.
    - From READ: cmd WRITE, txd = ack_i.
    - From WRITE: cmd READ.
- ACK, on core_ack:
  - ack_o <= core_rxd_i; dout_o <= shift reg.
  - stop -> STOP; else IDLE with cmd_ack_o=1 and cmd NOP.
- STOP, on core_ack: IDLE, cmd_ack_o=1, cmd NOP.
- core_al_i=1, in any state: next cycle state IDLE, cmd NOP, al_o=1 for one cycle, cmd_ack_o=0.
  - Takes precedence over a simultaneous core_ack_i.
  - Also takes precedence over a simultaneous new request.
- The READ data path leaves dout_o unchanged until ACK completes.

Optional Feature:
- Macro: I2C_BYTE_SEQ_TIMEOUT_EN.
- Enabled:
  - A TO_W-bit counter clears in IDLE and on every core_ack_i, and increments otherwise.
  - On reaching TIMEOUT_CYCLES outside IDLE: next cycle state IDLE, cmd NOP, timeout_o=1 for one cycle, no cmd_ack_o.
  - core_al_i has priority over timeout.
- Disabled: counter absent; timeout_o tied 0.

Decomposition:
- Command encodings go in the shared i2c_define.sv: I2C_CMD_NOP=4'b0000, START=4'b0001, STOP=4'b0010, WRITE=4'b0100, READ=4'b1000.
- The sequencer state encoding (one-hot) also goes in i2c_define.sv.
- One natural sub-module: i2c_byte_shreg (8-bit shift register with load/shift/3-bit counter and done flag).

Test Plan:
1. start+write, din=8'hA5; slave returns rxd=0 on ACK.
   - Required: cmds START, WRITE×8 with txd 1,0,1,0,0,1,0,1, then READ.
   - Required: ack_o=0; single cmd_ack_o pulse.
2. read+stop, ack_i=1; rxd bits 0,0,1,1,1,1,0,0.
   - Required: dout_o=8'h3C; ACK cmd WRITE with txd=1; then STOP; cmd_ack_o only after the STOP ack.
3. Write with core_al_i pulse after the 4th data ack.
   - Required: next cycle state IDLE, cmd NOP, al_o=1 for one cycle, no cmd_ack_o.
4. stop_i alone.
   - Required: single STOP cmd, then cmd_ack_o; dout_o and ack_o unchanged.
5. rst_i asserted mid-read, bit 5.
   - Required: next cycle all outputs at reset values; a subsequent write of 8'h01 completes normally.
6. With I2C_BYTE_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100; core_ack withheld during WRITE.
   - Required: timeout_o pulse at cycle 100, return to IDLE.
   - Without the macro: timeout_o stays 0.
